// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: entry layout and PC arithmetic.
package ifq_pkg;

   localparam int IFQ_ADDR_W  = 5;
   localparam int IFQ_INSTR_W = 32;

   typedef struct packed {
      logic [IFQ_ADDR_W-1:0]  pc;
      logic [IFQ_INSTR_W-1:0] instr;
   } ifq_entry_t;

   // Word-address increment; wraps modulo 2^IFQ_ADDR_W.
   function automatic logic [IFQ_ADDR_W-1:0] pc_inc(input logic [IFQ_ADDR_W-1:0] pc);
      return pc + IFQ_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries. Flush beats push in the
// same cycle, so a response landing during a redirect is simply dropped.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  ifq_entry_t             push_entry_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output ifq_entry_t             head_o
);

   localparam int AW = $clog2(DEPTH);

   ifq_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // Pointer and count update; flush clears everything regardless of push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
      !(push_i && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/ifq_fetch_queue.sv
// Instruction fetch stage: issues word reads to a synchronous program memory,
// tracks the single outstanding read, buffers responses with their PC and
// hands them to the decoder over valid/ready. A redirect flushes and restarts.
// Optional feature macro: IFQ_BYPASS_EN (empty-FIFO response goes straight to
// the decoder). Entry fields follow the ifq_pkg widths; keep ADDR_W/INSTR_W
// equal to IFQ_ADDR_W/IFQ_INSTR_W.
module ifq_fetch_queue
   import ifq_pkg::*;
#(
   parameter int ADDR_W  = IFQ_ADDR_W,
   parameter int INSTR_W = IFQ_INSTR_W,
   parameter int DEPTH   = 4
)
(
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INSTR_W-1:0]     imem_data,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_addr,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_W-1:0]     instr_data,
   output logic [ADDR_W-1:0]      instr_pc,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic              inflight_q, inflight_d;

   logic              resp_live;
   logic              bypass;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [CW-1:0]     count;
   logic [SW-1:0]     credit_sum;
   ifq_entry_t        push_entry;
   ifq_entry_t        head;

   // A response landing in the redirect cycle belongs to the old stream.
   assign resp_live  = inflight_q && !redirect_valid;
   assign fifo_empty = (count == '0);

`ifdef IFQ_BYPASS_EN
   assign bypass = resp_live && fifo_empty && instr_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push = resp_live && !bypass;
   assign pop  = !fifo_empty && instr_ready;

   // Counts next-cycle occupancy plus the outstanding read so a stalled
   // decoder can never cause an overflow.
   assign credit_sum = SW'(count) + SW'(inflight_q) + SW'(push) - SW'(pop);
   assign imem_req   = !reset && !redirect_valid && (credit_sum < SW'(DEPTH));
   assign imem_addr  = fetch_pc_q;

   assign push_entry = '{pc: resp_pc_q, instr: imem_data};

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .count_o      (count),
      .head_o       (head)
   );

   assign instr_valid = !fifo_empty || bypass;
   assign instr_data  = bypass ? imem_data : head.instr;
   assign instr_pc    = bypass ? resp_pc_q : head.pc;
   assign occupancy   = count;

   // Fetch PC sequencing and outstanding-read tracking.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = imem_req;
      if (redirect_valid) begin
         fetch_pc_d = redirect_addr;
      end else if (imem_req) begin
         fetch_pc_d = pc_inc(fetch_pc_q);
         resp_pc_d  = fetch_pc_q;
      end
   end

   // Fetch state registers; reset also discards an in-flight response.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= '0;
         resp_pc_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_ifq_fetch_queue.sv
`timescale 1ns/1ps
module tb_ifq_fetch_queue;

   localparam int ADDR_W  = 5;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 4;
`ifdef IFQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   imem_req;
   logic [ADDR_W-1:0]      imem_addr;
   logic [INSTR_W-1:0]     imem_data;
   logic                   redirect_valid;
   logic [ADDR_W-1:0]      redirect_addr;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [INSTR_W-1:0]     instr_data;
   logic [ADDR_W-1:0]      instr_pc;
   logic [$clog2(DEPTH):0] occupancy;

   always #5 clk = ~clk;

   ifq_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .occupancy      (occupancy)
   );

   function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return 32'h1000 + {{(INSTR_W-ADDR_W){1'b0}}, a};
   endfunction

   // synchronous program memory: data valid the cycle after the strobe
   always @(posedge clk) if (imem_req) imem_data <= mem_word(imem_addr);

   int n_chk  = 0;
   int n_fail = 0;
   int n_hs   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: delivered stream is consecutive PCs from the last restart point
   logic [ADDR_W+INSTR_W-1:0] exp_q[$];
   logic [ADDR_W-1:0]         redir_q[$];
   logic [ADDR_W-1:0]         got_q[$];
   logic [ADDR_W-1:0]         mdl_pc = '0;

   task automatic sb_refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back({mdl_pc, mem_word(mdl_pc)});
         mdl_pc = mdl_pc + 5'd1;
      end
   endtask

   // monitor: handshake of this cycle completes before any restart takes effect
   always @(negedge clk) begin : monitor
      logic [ADDR_W+INSTR_W-1:0] e;
      if (!reset) begin
         if (instr_valid && instr_ready) begin
            sb_refill();
            e = exp_q.pop_front();
            chk("hs_pc", 64'(instr_pc), 64'(e[ADDR_W+INSTR_W-1:INSTR_W]));
            chk("hs_data", 64'(instr_data), 64'(e[INSTR_W-1:0]));
            got_q.push_back(instr_pc);
            n_hs++;
         end
         chk("occ_le_depth", 64'(occupancy <= DEPTH), 64'd1);
         if (occupancy != 0) chk("valid_when_occ", 64'(instr_valid), 64'd1);
         if (redirect_valid) chk("no_req_on_redirect", 64'(imem_req), 64'd0);
      end
      if (redir_q.size() > 0) begin
         exp_q.delete();
         mdl_pc = redir_q.pop_front();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [ADDR_W-1:0] a);
      redirect_valid = 1'b1;
      redirect_addr  = a;
      redir_q.push_back(a);
   endtask

   task automatic wait_got(input int n, input string name);
      int k = 0;
      while (got_q.size() < n && k < 50) begin
         tick();
         k++;
      end
      chk(name, 64'(got_q.size() >= n), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic              found;
      logic              last_req;
      logic              prev_redir;
      logic [ADDR_W-1:0] prev_addr;

      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      instr_ready    = 1'b0;
      redir_q.push_back('0);
      repeat (3) tick();

      chk("rst_imem_req", 64'(imem_req), 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_instr_data", 64'(instr_data), 64'd0);
      chk("rst_instr_pc", 64'(instr_pc), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);

      // cycle 0: first cycle out of reset
      reset       = 1'b0;
      instr_ready = 1'b1;
      #1;
      chk("c0_req", 64'(imem_req), 64'd1);
      chk("c0_addr", 64'(imem_addr), 64'd0);
      chk("c0_valid", 64'(instr_valid), 64'd0);
      tick();
      chk("c1_req", 64'(imem_req), 64'd1);
      chk("c1_addr", 64'(imem_addr), 64'd1);
      chk("c1_valid", 64'(instr_valid), 64'(LAT == 1));
      tick();
      chk("c2_valid", 64'(instr_valid), 64'd1);
      chk("c2_pc", 64'(instr_pc), 64'(LAT == 1));
      chk("c2_data", 64'(instr_data), 64'(32'h1000 + (LAT == 1)));
      chk("c2_occ", 64'(occupancy), 64'(LAT == 2));
      chk("c2_addr", 64'(imem_addr), 64'd2);
      repeat (6) tick();

      // stall: FIFO fills to DEPTH and requests stop
      instr_ready = 1'b0;
      repeat (10) tick();
      chk("stall_occ", 64'(occupancy), 64'(DEPTH));
      chk("stall_req", 64'(imem_req), 64'd0);
      chk("stall_valid", 64'(instr_valid), 64'd1);
      instr_ready = 1'b1;
      got_q.delete();
      repeat (12) tick();
      chk("drain_progress", 64'(got_q.size() >= 8), 64'd1);

      // wrap: 30, 31, 0, 1
      redirect_to(5'd30);
      tick();
      redirect_valid = 1'b0;
      got_q.delete();
      wait_got(4, "wrap_wait");
      if (got_q.size() >= 4) begin
         chk("wrap_pc0", 64'(got_q[0]), 64'd30);
         chk("wrap_pc1", 64'(got_q[1]), 64'd31);
         chk("wrap_pc2", 64'(got_q[2]), 64'd0);
         chk("wrap_pc3", 64'(got_q[3]), 64'd1);
      end

      // redirect with 3 buffered entries and one read outstanding
      instr_ready = 1'b0;
      found       = 1'b0;
      last_req    = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (occupancy == 3 && last_req) found = 1'b1;
         else begin
            last_req = imem_req;
            tick();
         end
      end
      chk("redir12_setup", 64'(found), 64'd1);
      redirect_to(5'd12);
      #1;
      chk("redir12_R_req", 64'(imem_req), 64'd0);
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      #1;
      chk("redir12_R1_occ", 64'(occupancy), 64'd0);
      chk("redir12_R1_addr", 64'(imem_addr), 64'd12);
      chk("redir12_R1_req", 64'(imem_req), 64'd1);
      chk("redir12_R1_valid", 64'(instr_valid), 64'd0);
      tick();
      chk("redir12_R2_valid", 64'(instr_valid), 64'(LAT == 1));
      tick();
      chk("redir12_R3_valid", 64'(instr_valid), 64'd1);
      chk("redir12_R3_pc", 64'(instr_pc), 64'(12 + (LAT == 1)));
      repeat (4) tick();

      // back-to-back redirects: last one wins
      redirect_to(5'd5);
      tick();
      redirect_to(5'd9);
      tick();
      redirect_valid = 1'b0;
      got_q.delete();
      wait_got(1, "redir_b2b_wait");
      if (got_q.size() >= 1) chk("redir_b2b_first", 64'(got_q[0]), 64'd9);

      // reset during a stall with 2 entries buffered
      instr_ready = 1'b0;
      redirect_to(5'd20);
      tick();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (occupancy == 2) found = 1'b1;
         else tick();
      end
      chk("rst_mid_setup", 64'(found), 64'd1);
      reset = 1'b1;
      redir_q.push_back('0);
      tick();
      chk("rst_mid_req", 64'(imem_req), 64'd0);
      chk("rst_mid_addr", 64'(imem_addr), 64'd0);
      chk("rst_mid_valid", 64'(instr_valid), 64'd0);
      chk("rst_mid_data", 64'(instr_data), 64'd0);
      chk("rst_mid_pc", 64'(instr_pc), 64'd0);
      chk("rst_mid_occ", 64'(occupancy), 64'd0);
      reset       = 1'b0;
      instr_ready = 1'b1;
      #1;
      chk("rst_mid_restart_addr", 64'(imem_addr), 64'd0);
      chk("rst_mid_restart_req", 64'(imem_req), 64'd1);
      got_q.delete();
      wait_got(1, "rst_mid_wait");
      if (got_q.size() >= 1) chk("rst_mid_first_pc", 64'(got_q[0]), 64'd0);

      // randomized traffic: stalls and redirects against the stream model
      n_hs       = 0;
      prev_redir = 1'b0;
      prev_addr  = '0;
      for (int c = 0; c < 3000; c++) begin
         instr_ready = ($urandom_range(3) != 0);
         if ($urandom_range(19) == 0) redirect_to(ADDR_W'($urandom_range(31)));
         else redirect_valid = 1'b0;
         if (prev_redir) begin
            #1;
            chk("rand_post_redir_occ", 64'(occupancy), 64'd0);
            chk("rand_post_redir_addr", 64'(imem_addr), 64'(prev_addr));
         end
         prev_redir = redirect_valid;
         prev_addr  = redirect_addr;
         tick();
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      repeat (5) tick();
      chk("rand_progress", 64'(n_hs > 500), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
